// File: rtl/cpu_core.sv
// cpu_core: multi-cycle accumulator-style core, 4-bit-opcode ISA, single req/ack memory port.
// Define CPU_CORE_MUL_EN to implement opcode 0100 as a hardware multiply (otherwise it is a NOP).
module cpu_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int CC_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              halt,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CC_W-1:0]   cycle_count,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  // state    | meaning
  // S_IDLE   | waiting for start
  // S_FETCH  | reading instruction byte at pc
  // S_IMM    | reading immediate/target word at pc, then retiring the op
  // S_EXEC   | ALU op (one cycle) or LD/ST transfer (until ack)
  // S_HALTED | stopped until reset
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_IMM, S_EXEC, S_HALTED} state_t;

  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_ADDI  = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0011;
  localparam logic [3:0] OP_MUL   = 4'b0100;
  localparam logic [3:0] OP_NEG   = 4'b0110;
  localparam logic [3:0] OP_BGEZ0 = 4'b1000;
  localparam logic [3:0] OP_BGEZ1 = 4'b1001;
  localparam logic [3:0] OP_MOVE  = 4'b1010;
  localparam logic [3:0] OP_ST    = 4'b1011;
  localparam logic [3:0] OP_LD    = 4'b1100;
  localparam logic [3:0] OP_LI    = 4'b1101;
  localparam logic [3:0] OP_J     = 4'b1110;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        ir;
  logic [DATA_W-1:0] regs [4];

  logic [3:0]        opcode, f_op;
  logic [1:0]        rd, rs, f_rd, f_rs;
  logic [DATA_W-1:0] rd_val, rs_val, alu_res;
  logic              alu_we;
  logic              f_needs_imm, f_is_mem, ex_is_mem;
  logic              br_taken, ack;
  logic [ADDR_W-1:0] pc_inc, imm_next_pc;

  assign opcode = ir[7:4];
  assign rd     = ir[3:2];
  assign rs     = ir[1:0];
  assign f_op   = mem_rdata[7:4];
  assign f_rd   = mem_rdata[3:2];
  assign f_rs   = mem_rdata[1:0];

  assign rd_val   = regs[rd];
  assign rs_val   = regs[rs];
  assign dbg_data = regs[dbg_sel];

  assign ack         = mem_req & mem_ack;
  assign pc_inc      = pc + ADDR_W'(1);
  assign f_needs_imm = f_op inside {OP_ADDI, OP_LI, OP_BGEZ0, OP_BGEZ1, OP_J};
  assign f_is_mem    = f_op inside {OP_ST, OP_LD};
  assign ex_is_mem   = opcode inside {OP_ST, OP_LD};

  always_comb begin
    alu_res = rd_val;
    alu_we  = 1'b0;
    case (opcode)
      OP_ADD:  begin alu_res = rd_val + rs_val;     alu_we = 1'b1; end
      OP_SUB:  begin alu_res = rd_val - rs_val;     alu_we = 1'b1; end
`ifdef CPU_CORE_MUL_EN
      OP_MUL:  begin alu_res = rd_val * rs_val;     alu_we = 1'b1; end
`endif
      OP_NEG:  begin alu_res = DATA_W'(0) - rs_val; alu_we = 1'b1; end
      OP_MOVE: begin alu_res = rs_val;              alu_we = 1'b1; end
      default: ;
    endcase
  end

  // Branch condition is the sign bit of r0/r1: clear means signed >= 0.
  always_comb begin
    br_taken = 1'b0;
    case (opcode)
      OP_BGEZ0: br_taken = ~regs[0][DATA_W-1];
      OP_BGEZ1: br_taken = ~regs[1][DATA_W-1];
      OP_J:     br_taken = 1'b1;
      default:  ;
    endcase
  end

  assign imm_next_pc = br_taken ? ADDR_W'(mem_rdata) : pc_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      ir          <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      cycle_count <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      halt        <= 1'b0;
    end else begin
      if ((state inside {S_FETCH, S_IMM, S_EXEC}) && (cycle_count != '1))
        cycle_count <= cycle_count + CC_W'(1);

      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end
        end

        S_FETCH: begin
          if (ack) begin
            ir <= mem_rdata[7:0];
            pc <= pc_inc;
            if (f_op == OP_HALT) begin
              state   <= S_HALTED;
              halt    <= 1'b1;
              mem_req <= 1'b0;
            end else if (f_needs_imm) begin
              state    <= S_IMM;
              mem_req  <= 1'b1;
              mem_addr <= pc_inc;
            end else if (f_is_mem) begin
              // Transfer attributes are set here and held until the data ack.
              state    <= S_EXEC;
              mem_req  <= 1'b1;
              mem_we   <= (f_op == OP_ST);
              mem_addr <= ADDR_W'(regs[f_rs]);
              if (f_op == OP_ST) mem_wdata <= regs[f_rd];
            end else begin
              state   <= S_EXEC;
              mem_req <= 1'b0;
            end
          end
        end

        S_IMM: begin
          if (ack) begin
            case (opcode)
              OP_ADDI: regs[rd] <= rd_val + mem_rdata;
              OP_LI:   regs[rd] <= mem_rdata;
              default: ;
            endcase
            pc       <= imm_next_pc;
            mem_addr <= imm_next_pc;
            mem_req  <= 1'b1;
            state    <= S_FETCH;
          end
        end

        S_EXEC: begin
          if (ex_is_mem) begin
            if (ack) begin
              if (opcode == OP_LD) regs[rd] <= mem_rdata;
              mem_we   <= 1'b0;
              mem_req  <= 1'b1;
              mem_addr <= pc;
              state    <= S_FETCH;
            end
          end else begin
            if (alu_we) regs[rd] <= alu_res;
            mem_we   <= 1'b0;
            mem_req  <= 1'b1;
            mem_addr <= pc;
            state    <= S_FETCH;
          end
        end

        S_HALTED: ;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: scoreboard bench for cpu_core; memory model with programmable wait states on data addresses.
`timescale 1ns/1ps
module tb_cpu_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        halt;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [15:0] cycle_count;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;

  cpu_core dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .cycle_count(cycle_count), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [256];
  int          data_wait;
  int          wcnt;
  logic [16:0] exp_q [$];
  int          n_checks;
  int          n_pass;
  int          we_cycles;
  logic        we_changed;
  logic [7:0]  we_addr, we_data;

  // Addresses at 0x30 and above are the data region and see data_wait wait states.
  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = mem_req && (wcnt >= ((mem_addr >= 8'h30) ? data_wait : 0));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   wcnt <= 0;
    else if (!mem_req || mem_ack) wcnt <= 0;
    else                          wcnt <= wcnt + 1;
  end

  task automatic push_rd(input logic [7:0] a);
    exp_q.push_back({1'b0, a, 8'h00});
  endtask

  task automatic push_rd_seq(input logic [7:0] a, input int n);
    for (int i = 0; i < n; i++) push_rd(8'(a + i));
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({1'b1, a, d});
  endtask

  // Bytes are right-justified: the first byte of the program is the most significant one.
  task automatic load_prog(input logic [7:0] base, input logic [127:0] bytes, input int n);
    for (int i = 0; i < n; i++) mem[8'(base + i)] = bytes[8*(n-1-i) +: 8];
  endtask

  task automatic apply_reset;
    start     = 1'b0;
    dbg_sel   = 2'd0;
    data_wait = 0;
    rst_n     = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic get_reg(input logic [1:0] s, output logic [7:0] v);
    dbg_sel = s;
    #1;
    v = dbg_data;
  endtask

  // Pulses start, then pops the scoreboard on every completed transfer until halt.
  task automatic run_prog(input int budget);
    bit          done;
    logic [16:0] act, exp;
    we_cycles  = 0;
    we_changed = 1'b0;
    we_addr    = 8'h00;
    we_data    = 8'h00;
    done       = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_req && mem_we) begin
        if (we_cycles == 0) begin
          we_addr = mem_addr;
          we_data = mem_wdata;
        end else if (mem_addr !== we_addr || mem_wdata !== we_data) begin
          we_changed = 1'b1;
        end
        we_cycles++;
      end
      if (mem_req && mem_ack) begin
        act = {mem_we, mem_addr, mem_we ? mem_wdata : 8'h00};
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_extra got %h want none", act);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) $display("FAIL sb_txn got %h want %h", act, exp);
          else n_pass++;
        end
        if (mem_we) mem[mem_addr] = mem_wdata;
      end
      if (halt) done = 1'b1;
    end
    n_checks++;
    if (!done) $display("FAIL run_timeout got halt=%b want 1 within %0d cycles", halt, budget);
    else if (exp_q.size() != 0) $display("FAIL sb_missing got %0d pending want 0", exp_q.size());
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_reset;
    logic [7:0] v;
    apply_reset();
    n_checks++; if (halt !== 1'b0)       $display("FAIL rst_halt got %b want 0", halt);               else n_pass++;
    n_checks++; if (mem_req !== 1'b0)    $display("FAIL rst_req got %b want 0", mem_req);             else n_pass++;
    n_checks++; if (mem_we !== 1'b0)     $display("FAIL rst_we got %b want 0", mem_we);               else n_pass++;
    n_checks++; if (mem_addr !== 8'h00)  $display("FAIL rst_addr got %h want 00", mem_addr);          else n_pass++;
    n_checks++; if (mem_wdata !== 8'h00) $display("FAIL rst_wdata got %h want 00", mem_wdata);        else n_pass++;
    n_checks++; if (cycle_count !== 16'd0) $display("FAIL rst_cc got %0d want 0", cycle_count);       else n_pass++;
    for (int i = 0; i < 4; i++) begin
      get_reg(2'(i), v);
      n_checks++; if (v !== 8'h00) $display("FAIL rst_r%0d got %h want 00", i, v); else n_pass++;
    end
  endtask

  task automatic test_program;
    logic [7:0] v;
    apply_reset();
    load_prog(8'h00, 128'hD005D40311F0, 6);
    push_rd_seq(8'h00, 6);
    run_prog(100);
    get_reg(2'd0, v);
    n_checks++; if (v !== 8'h08) $display("FAIL prog_r0 got %h want 08", v); else n_pass++;
    get_reg(2'd1, v);
    n_checks++; if (v !== 8'h03) $display("FAIL prog_r1 got %h want 03", v); else n_pass++;
    n_checks++; if (halt !== 1'b1) $display("FAIL prog_halt got %b want 1", halt); else n_pass++;
    n_checks++; if (cycle_count !== 16'd7) $display("FAIL prog_cc got %0d want 7", cycle_count); else n_pass++;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (cycle_count !== 16'd7) $display("FAIL halted_cc got %0d want 7", cycle_count); else n_pass++;
    n_checks++; if (halt !== 1'b1 || mem_req !== 1'b0)
      $display("FAIL halted_state got halt=%b req=%b want halt=1 req=0", halt, mem_req); else n_pass++;
  endtask

  task automatic test_addi_wrap;
    logic [7:0] v;
    apply_reset();
    load_prog(8'h00, 128'hD00120FFF0, 5);
    push_rd_seq(8'h00, 5);
    run_prog(100);
    get_reg(2'd0, v);
    n_checks++; if (v !== 8'h00) $display("FAIL addi_r0 got %h want 00", v); else n_pass++;
    n_checks++; if (cycle_count !== 16'd5) $display("FAIL addi_cc got %0d want 5", cycle_count); else n_pass++;
  endtask

  task automatic test_alu;
    logic [7:0] v;
    logic [7:0] want [4];
    want[0] = 8'hFE; want[1] = 8'h07; want[2] = 8'hF9; want[3] = 8'hFE;
    apply_reset();
    load_prog(8'h00, 128'hD005D4073169AC507000F0, 11);
    push_rd_seq(8'h00, 11);
    run_prog(100);
    for (int i = 0; i < 4; i++) begin
      get_reg(2'(i), v);
      n_checks++; if (v !== want[i]) $display("FAIL alu_r%0d got %h want %h", i, v, want[i]); else n_pass++;
    end
    n_checks++; if (cycle_count !== 16'd17) $display("FAIL alu_cc got %0d want 17", cycle_count); else n_pass++;
  endtask

  task automatic test_branch;
    logic [7:0] v;
    apply_reset();
    load_prog(8'h00, 128'hD0808040F0, 5);
    load_prog(8'h40, 128'hD477F0, 3);
    push_rd_seq(8'h00, 5);
    run_prog(100);
    get_reg(2'd1, v);
    n_checks++; if (v !== 8'h00) $display("FAIL bgez_neg_r1 got %h want 00", v); else n_pass++;
    n_checks++; if (cycle_count !== 16'd5) $display("FAIL bgez_neg_cc got %0d want 5", cycle_count); else n_pass++;

    apply_reset();
    load_prog(8'h00, 128'hD07F8040F0, 5);
    load_prog(8'h40, 128'hD477F0, 3);
    push_rd_seq(8'h00, 4);
    push_rd_seq(8'h40, 3);
    run_prog(100);
    get_reg(2'd1, v);
    n_checks++; if (v !== 8'h77) $display("FAIL bgez_pos_r1 got %h want 77", v); else n_pass++;
    n_checks++; if (cycle_count !== 16'd7) $display("FAIL bgez_pos_cc got %0d want 7", cycle_count); else n_pass++;
  endtask

  task automatic test_jump;
    apply_reset();
    load_prog(8'h00, 128'hE010, 2);
    load_prog(8'h10, 128'h9020, 2);
    load_prog(8'h20, 128'hF0, 1);
    push_rd(8'h00); push_rd(8'h01);
    push_rd(8'h10); push_rd(8'h11);
    push_rd(8'h20);
    run_prog(100);
    n_checks++; if (cycle_count !== 16'd5) $display("FAIL jump_cc got %0d want 5", cycle_count); else n_pass++;
  endtask

  task automatic test_store_wait;
    logic [7:0] v;
    apply_reset();
    data_wait = 3;
    load_prog(8'h00, 128'hD8A5DC30BBC7F0, 7);
    push_rd_seq(8'h00, 5);
    push_wr(8'h30, 8'hA5);
    push_rd(8'h05);
    push_rd(8'h30);
    push_rd(8'h06);
    run_prog(200);
    n_checks++; if (we_cycles !== 4) $display("FAIL st_hold_cycles got %0d want 4", we_cycles); else n_pass++;
    n_checks++; if (we_changed !== 1'b0) $display("FAIL st_stable got %b want 0", we_changed); else n_pass++;
    n_checks++; if (we_addr !== 8'h30) $display("FAIL st_addr got %h want 30", we_addr); else n_pass++;
    n_checks++; if (we_data !== 8'hA5) $display("FAIL st_wdata got %h want a5", we_data); else n_pass++;
    n_checks++; if (mem[8'h30] !== 8'hA5) $display("FAIL st_mem got %h want a5", mem[8'h30]); else n_pass++;
    get_reg(2'd1, v);
    n_checks++; if (v !== 8'hA5) $display("FAIL ld_r1 got %h want a5", v); else n_pass++;
    n_checks++; if (cycle_count !== 16'd15) $display("FAIL st_cc got %0d want 15", cycle_count); else n_pass++;
  endtask

  task automatic test_mul;
    logic [7:0] v;
    logic [7:0] want2;
`ifdef CPU_CORE_MUL_EN
    want2 = 8'h0F;
`else
    want2 = 8'h03;
`endif
    apply_reset();
    load_prog(8'h00, 128'hD810DC114BF0, 6);
    push_rd_seq(8'h00, 6);
    run_prog(100);
    get_reg(2'd2, v);
    n_checks++; if (v !== 8'h10) $display("FAIL mul_a_r2 got %h want 10", v); else n_pass++;

    apply_reset();
    load_prog(8'h00, 128'hD803DC054BF0, 6);
    push_rd_seq(8'h00, 6);
    run_prog(100);
    get_reg(2'd2, v);
    n_checks++; if (v !== want2) $display("FAIL mul_b_r2 got %h want %h", v, want2); else n_pass++;
    get_reg(2'd3, v);
    n_checks++; if (v !== 8'h05) $display("FAIL mul_b_r3 got %h want 05", v); else n_pass++;
    n_checks++; if (cycle_count !== 16'd7) $display("FAIL mul_cc got %0d want 7", cycle_count); else n_pass++;
  endtask

  task automatic test_reset_mid_ld;
    logic [7:0] v;
    bit         seen;
    apply_reset();
    data_wait = 20;
    load_prog(8'h00, 128'hD440C5F0, 4);
    mem[8'h40] = 8'h5A;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (mem_req && !mem_we && mem_addr == 8'h40) seen = 1'b1;
    end
    n_checks++; if (!seen) $display("FAIL ld_issue got seen=0 want 1"); else n_pass++;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL async_req got %b want 0", mem_req); else n_pass++;
    n_checks++; if (cycle_count !== 16'd0) $display("FAIL async_cc got %0d want 0", cycle_count); else n_pass++;
    get_reg(2'd1, v);
    n_checks++; if (v !== 8'h00) $display("FAIL async_r1 got %h want 00", v); else n_pass++;
    data_wait = 0;
    @(negedge clk);
    rst_n = 1'b1;
    push_rd_seq(8'h00, 3);
    push_rd(8'h40);
    push_rd(8'h03);
    run_prog(100);
    get_reg(2'd1, v);
    n_checks++; if (v !== 8'h5A) $display("FAIL restart_r1 got %h want 5a", v); else n_pass++;
    n_checks++; if (cycle_count !== 16'd5) $display("FAIL restart_cc got %0d want 5", cycle_count); else n_pass++;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    dbg_sel   = 2'd0;
    data_wait = 0;
    test_reset();
    test_program();
    test_addi_wrap();
    test_alu();
    test_branch();
    test_jump();
    test_store_wait();
    test_mul();
    test_reset_mid_ld();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_core.md
# cpu_core

Parametrised multi-cycle accumulator-style processor core: the next generation of the team's 8-bit teaching CPU. It fetches 8-bit instructions, and optional immediate words, over a single req/ack memory port. It executes the established 4-bit-opcode ISA on four general registers of configurable width and counts execution cycles. It sits between the top-level `start`/`halt` control and the shared program/data memory.

## Interface
Parameters:
- `DATA_W`, 8: register, ALU and memory data width; must be >= 8.
- `ADDR_W`, 8: program counter and memory address width.
- `CC_W`, 16: cycle-counter width.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begins execution; sampled only in IDLE.
- `halt` output 1: high while in HALTED.
- `mem_req` output 1: memory transfer request.
- `mem_we` output 1: 1 = write, 0 = read.
- `mem_addr` output ADDR_W: transfer address.
- `mem_wdata` output DATA_W: write data.
- `mem_rdata` input DATA_W: read data, valid in the cycle `mem_ack` is high.
- `mem_ack` input 1: transfer completes at the rising edge where `mem_req & mem_ack`.
- `cycle_count` output CC_W: executed-cycle count.
- `dbg_sel` input 2: register select for the debug port.
- `dbg_data` output DATA_W: combinational read of register r[`dbg_sel`].

## Operation
- Instruction byte `ir = mem_rdata[7:0]` is split as follows:
  - opcode = ir[7:4]
  - rd = ir[3:2]
  - rs = ir[1:0]
- Immediate/target word: the memory word at pc+1. It is fetched for ADDi, LI, BGEZ0, BGEZ1 and J.
- ALU and data operations:
  - 0000 NOP.
  - 0001 ADD: rd = rd + rs.
  - 0010 ADDi: rd = rd + imm.
  - 0011 SUB: rd = rd - rs.
  - 0100 MUL: rd = low DATA_W bits of rd * rs.
  - 0110 NEG: rd = -rs.
  - 1010 MOVE: rd = rs.
  - 1011 ST: mem[rs] = rd.
  - 1100 LD: rd = mem[rs].
  - 1101 LI: rd = imm.
- Control-flow operations:
  - 1000 BGEZ0: pc = target if r0 is signed >= 0.
  - 1001 BGEZ1: same test on r1.
  - 1110 J: pc = target.
  - 1111 HALT.
  - 0101 and 0111 behave as NOP.
- For ST/LD addresses, rs is truncated to ADDR_W bits, or zero-extended if narrower.
- Arithmetic is modulo 2^DATA_W. No flags; wrap-around is silent.
- States:
  - IDLE: `start` -> FETCH.
  - FETCH: on ack, latch ir and pc += 1. Go to IMM for immediate ops, HALTED for HALT, otherwise EXEC.
  - IMM: read at pc; on ack, perform the op and go to FETCH. Branches set pc = target if taken, else pc += 1. LI/ADDi set pc += 1.
  - EXEC: ALU ops retire in one cycle. LD/ST issue a memory request and retire on ack. Then FETCH.
  - HALTED: terminal; exit only by reset.
- pc wraps from 2^ADDR_W-1 to 0.
- `mem_req` is high only in FETCH, IMM, and LD/ST EXEC. `mem_we` is high only for ST.
- `cycle_count` increments in every cycle spent in FETCH, IMM or EXEC, including wait cycles. It saturates at all-ones.

## Timing
- Reset values: pc, r0-r3, ir, `cycle_count`, `mem_addr`, `mem_wdata` = 0; `mem_req`, `mem_we`, `halt` = 0; state = IDLE.
- Reset is asynchronous: asserting `rst_n` low mid-transfer drops `mem_req` immediately. A pending ST performs no write from the core's side.
- Once `mem_req` is raised, `mem_addr`, `mem_we` and `mem_wdata` stay constant until the ack edge.
- `mem_ack` may be high in the same cycle `mem_req` rises, which is zero-wait.
- With zero-wait memory, every instruction takes exactly 2 cycles (FETCH plus IMM or EXEC). HALT takes 1 cycle.
- Each wait cycle adds 1.
- `halt` rises at the edge that completes the HALT fetch.
- `start` pulses outside IDLE are ignored.
- `mem_ack` without `mem_req` is ignored.

## Configuration
- `CPU_CORE_MUL_EN` defined: MUL is implemented as a combinational DATA_W x DATA_W multiply, low half kept.
- `CPU_CORE_MUL_EN` undefined: no multiplier is instantiated, and opcode 0100 executes as NOP (2 cycles, registers unchanged).

## Test plan
- Program D0 05 D4 03 11 F0 with zero-wait memory, DATA_W=8 -> r0=0x08, r1=0x03, `halt`=1, `cycle_count`=7.
- r0=0x01, then ADDi r0 (0x20, imm 0xFF) -> r0=0x00 (wrap-around), pc advances by 2.
- BGEZ0 with r0=0x80 -> falls through to pc+2. BGEZ0 with r0=0x7F and target 0x40 -> next fetch address 0x40.
- ST r2 to [r3] with r3=0x30, r2=0xA5, and `mem_ack` delayed 3 cycles -> `mem_req`/`mem_we`/`mem_addr`=0x30/`mem_wdata`=0xA5 held 4 cycles, `cycle_count` +5 for the instruction.
- MUL r2,r3 with r2=0x10, r3=0x11 -> r2=0x10 when `CPU_CORE_MUL_EN` is defined, r2 unchanged when undefined.
- Assert `rst_n` low mid-LD wait, then release and pulse `start` -> `mem_req` low immediately, all registers 0, fetch restarts at address 0.
